guess_game_ctrl: RTL and testbench

Central sequencer for the number-guessing game. Synchronises and edge-detects the two push-buttons, gates the LFSR, latches the secret at game start, compares each guess against it, keeps the two-digit BCD guess count, and produces the game state code that drives the seven-segment output formatter. Sits between the raw board I/O and the LFSR, output-formatting and hex-display blocks.

---
 rtl/guess_game_ctrl_pkg.sv | 32 +++
 rtl/guess_game_ctrl_button_sync_edge.sv | 39 +++
 rtl/guess_game_ctrl.sv | 106 ++++++++++
 tb/tb_guess_game_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_ctrl_pkg.sv
// Shared definitions for the number-guessing game: state codes, BCD width,
// display glyph codes and the saturating two-digit BCD increment.
package guess_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_HIT  = 3'd4,
    ST_LOSE = 3'd5
  } game_state_t;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] GLYPH_P    = 4'd10;
  localparam logic [BCD_W-1:0] GLYPH_L    = 4'd11;
  localparam logic [BCD_W-1:0] GLYPH_A    = 4'd12;
  localparam logic [BCD_W-1:0] GLYPH_Y    = 4'd13;
  localparam logic [BCD_W-1:0] GLYPH_H    = 4'd14;
  localparam logic [BCD_W-1:0] GLYPH_DASH = 4'd15;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [2*BCD_W-1:0] bcd_inc_sat(input logic [2*BCD_W-1:0] c);
    if (c == 8'h99)
      return c;
    if (c[BCD_W-1:0] == 4'd9)
      return {c[2*BCD_W-1:BCD_W] + 4'd1, 4'd0};
    return {c[2*BCD_W-1:BCD_W], c[BCD_W-1:0] + 4'd1};
  endfunction

endpackage

// File: rtl/guess_game_ctrl_button_sync_edge.sv
// Two-flop synchroniser plus registered falling-edge detector for an
// active-low push-button; emits one single-cycle pulse per press.
module button_sync_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic i_btn_n,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_pulse;
  logic       r_armed;
  logic [1:0] r_fill;

  // Detection stays disarmed until the synchronised button has been seen
  // released, so a button held through reset release cannot fire.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_pulse <= 1'b0;
      r_armed <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & r_sync2);
      r_pulse <= r_armed & r_prev & ~r_sync2;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/guess_game_ctrl.sv
// Game sequencer: button pulses, secret latch, guess compare, BCD count, hold timer.
// Optional guess limit (LOSE state) enabled by defining GUESS_LIMIT_EN.
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter int N           = 10,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int MAX_GUESSES = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start_button,
  input  logic             Guess_button,
  input  logic [N-1:0]     guess,
  input  logic [N-1:0]     random,
  output logic             lfsr_run,
  output logic [2:0]       state,
  output logic [BCD_W-1:0] count0,
  output logic [BCD_W-1:0] count1
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES);
`ifdef GUESS_LIMIT_EN
  localparam logic [2*BCD_W-1:0] MAX_BCD = {4'(MAX_GUESSES / 10), 4'(MAX_GUESSES % 10)};
`endif

  logic               w_start_p;
  logic               w_guess_p;
  logic [2*BCD_W-1:0] w_count_inc;
  game_state_t        w_result;

  game_state_t        r_state;
  logic [N-1:0]       r_secret;
  logic [TW-1:0]      r_hold;
  logic [2*BCD_W-1:0] r_count;
  logic               r_lfsr_run;

  button_sync_edge u_start (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_btn_n (Start_button),
    .o_pulse (w_start_p)
  );

  button_sync_edge u_guess (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_btn_n (Guess_button),
    .o_pulse (w_guess_p)
  );

  always_comb begin
    w_count_inc = bcd_inc_sat(r_count);
    w_result    = ST_PLAY;
    if (guess == r_secret)
      w_result = ST_HIT;
`ifdef GUESS_LIMIT_EN
    else if (w_count_inc == MAX_BCD)
      w_result = ST_LOSE;
`endif
    else if (r_secret > guess)
      w_result = ST_LO;
    else
      w_result = ST_HI;
  end

  // Start has priority over everything, including a simultaneous guess.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_secret   <= '0;
      r_hold     <= '0;
      r_count    <= '0;
      r_lfsr_run <= 1'b1;
    end else if (w_start_p) begin
      r_secret   <= random;
      r_count    <= '0;
      r_state    <= ST_PLAY;
      r_lfsr_run <= 1'b0;
    end else begin
      case (r_state)
        ST_PLAY, ST_LO, ST_HI: begin
          if (w_guess_p) begin
            r_count    <= w_count_inc;
            r_state    <= w_result;
            r_hold     <= HOLD_LD;
            r_lfsr_run <= (w_result == ST_HIT) || (w_result == ST_LOSE);
          end else if (r_state != ST_PLAY) begin
            if (r_hold == '0)
              r_state <= ST_PLAY;
            else
              r_hold <= r_hold - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state    = r_state;
  assign lfsr_run = r_lfsr_run;
  assign count0   = r_count[BCD_W-1:0];
  assign count1   = r_count[2*BCD_W-1:BCD_W];

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl against a rule-level game model.
module tb_guess_game_ctrl;

  localparam int N    = 10;
  localparam int HOLD = 5;
  localparam int MAXG = 3;
`ifdef GUESS_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start_button = 1'b1;
  logic         Guess_button = 1'b1;
  logic [N-1:0] guess = '0;
  logic [N-1:0] random = '0;
  logic         lfsr_run;
  logic [2:0]   state;
  logic [3:0]   count0, count1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Game model: state code, integer guess count, secret, cycle of LO/HI entry.
  int           m_state = 0;
  int           m_cnt = 0;
  logic [N-1:0] m_secret = '0;
  int           m_entry = 0;

  guess_game_ctrl #(.N(N), .HOLD_CYCLES(HOLD), .MAX_GUESSES(MAXG)) dut (
    .Clock(Clock), .Reset(Reset), .Start_button(Start_button), .Guess_button(Guess_button),
    .guess(guess), .random(random), .lfsr_run(lfsr_run), .state(state),
    .count0(count0), .count1(count1)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  // A LO/HI result is shown for HOLD+1 samples after entry, then PLAY.
  function automatic int exp_state();
    if ((m_state == 2 || m_state == 3) && (cyc - m_entry) > HOLD)
      return 1;
    return m_state;
  endfunction

  task automatic press(input bit s, input bit g, input logic [N-1:0] gv, input string tag);
    int pre;
    int es;
    @(negedge Clock);
    guess = gv;
    Start_button = !s;
    Guess_button = !g;
    repeat (3) @(posedge Clock);
    #1;
    pre = exp_state();
    n_checks++;
    if (state !== 3'(pre)) begin
      n_errors++;
      $display("FAIL %s early_state: got %0d want %0d", tag, state, pre);
    end
    @(posedge Clock);
    #1;
    m_state = pre;
    if (s) begin
      m_state = 1; m_cnt = 0; m_secret = random;
    end else if (g && pre >= 1 && pre <= 3) begin
      m_cnt = (m_cnt < 99) ? m_cnt + 1 : 99;
      m_entry = cyc;
      if (gv == m_secret) m_state = 4;
      else if (LIMIT && m_cnt == MAXG) m_state = 5;
      else if (m_secret > gv) m_state = 2;
      else m_state = 3;
    end
    es = exp_state();
    n_checks += 3;
    if (state !== 3'(es)) begin
      n_errors++; $display("FAIL %s state: got %0d want %0d", tag, state, es);
    end
    if ({count1, count0} !== {4'(m_cnt / 10), 4'(m_cnt % 10)}) begin
      n_errors++; $display("FAIL %s count: got %0d%0d want %0d", tag, count1, count0, m_cnt);
    end
    if (lfsr_run !== (es == 0 || es == 4 || es == 5)) begin
      n_errors++; $display("FAIL %s lfsr_run: got %0b state %0d", tag, lfsr_run, es);
    end
    @(negedge Clock);
    Start_button = 1'b1;
    Guess_button = 1'b1;
    guess = N'($urandom);
  endtask

  task automatic idle(input int n, input string tag);
    int es;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      es = exp_state();
      n_checks += 3;
      if (state !== 3'(es)) begin
        n_errors++; $display("FAIL %s idle_state[%0d]: got %0d want %0d", tag, i, state, es);
      end
      if ({count1, count0} !== {4'(m_cnt / 10), 4'(m_cnt % 10)}) begin
        n_errors++; $display("FAIL %s idle_count[%0d]: got %0d%0d want %0d", tag, i, count1, count0, m_cnt);
      end
      if (lfsr_run !== (es == 0 || es == 4 || es == 5)) begin
        n_errors++; $display("FAIL %s idle_lfsr[%0d]: got %0b state %0d", tag, i, lfsr_run, es);
      end
    end
  endtask

  task automatic test_reset();
    #3 Reset = 1'b0;
    #1;
    n_checks++;
    if ({state, count1, count0, lfsr_run} !== {3'd0, 4'd0, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_values: got st=%0d cnt=%0d%0d run=%0b want 0 00 1", state, count1, count0, lfsr_run);
    end
    repeat (3) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    idle(6, "reset");
    press(0, 1, 10'h000, "guess_in_idle");
    idle(3, "guess_in_idle");
  endtask

  task automatic test_directed();
    random = 10'h155;
    press(1, 0, 10'h000, "start");
    n_checks++;
    if ({state, lfsr_run, count1, count0} !== {3'd1, 1'b0, 8'h00}) begin
      n_errors++; $display("FAIL start_abs: got st=%0d run=%0b cnt=%0d%0d", state, lfsr_run, count1, count0);
    end
    random = 10'h2AA;
    press(0, 1, 10'h100, "g_low");
    idle(8, "g_low");
    press(0, 1, 10'h200, "g_high");
    press(0, 1, 10'h155, "g_hit");
    n_checks++;
    if ({state, lfsr_run} !== {3'd4, 1'b1}) begin
      n_errors++; $display("FAIL hit_abs: got st=%0d run=%0b want 4 1", state, lfsr_run);
    end
    press(0, 1, 10'h100, "g_after_hit");
    idle(3, "after_hit");
  endtask

  task automatic test_hold();
    random = 10'h0F0;
    press(1, 0, 10'h000, "hold_start");
    press(0, 1, 10'h010, "hold_low");
    idle(10, "hold");
  endtask

  task automatic test_simultaneous();
    random = 10'h123;
    press(1, 0, 10'h000, "sim_start");
    press(0, 1, 10'h3FF, "sim_g1");
    random = 10'h0AB;
    press(1, 1, m_secret, "sim_both");
    idle(2, "sim_both");
    press(0, 1, 10'h0AB, "sim_newsecret");
  endtask

  task automatic test_saturation();
    random = 10'h201;
    press(1, 0, 10'h000, "sat_start");
    for (int i = 0; i < 100; i++)
      press(0, 1, m_secret ^ 10'h001, "sat_guess");
    n_checks++;
    if ({count1, count0} !== 8'h99) begin
      n_errors++; $display("FAIL saturation: got %0d%0d want 99", count1, count0);
    end
  endtask

  task automatic test_limit();
    random = 10'h077;
    press(1, 0, 10'h000, "lim_start");
    press(0, 1, 10'h001, "lim_g1");
    press(0, 1, 10'h3F0, "lim_g2");
    press(0, 1, 10'h002, "lim_g3");
    n_checks++;
    if ({state, lfsr_run} !== {3'd5, 1'b1}) begin
      n_errors++; $display("FAIL lose_abs: got st=%0d run=%0b want 5 1", state, lfsr_run);
    end
    press(0, 1, 10'h077, "lim_g4_ignored");
    press(1, 0, 10'h000, "lim_restart");
  endtask

  task automatic test_reset_midgame();
    random = 10'h155;
    press(1, 0, 10'h000, "rm_start");
    for (int i = 0; i < (LIMIT ? 1 : 6); i++)
      press(0, 1, 10'h100, "rm_low");
    press(0, 1, 10'h300, "rm_high");
    @(negedge Clock);
    #2 Reset = 1'b0;
    Start_button = 1'b0;
    #1;
    m_state = 0; m_cnt = 0; m_secret = '0;
    n_checks++;
    if ({state, count1, count0, lfsr_run} !== {3'd0, 8'h00, 1'b1}) begin
      n_errors++;
      $display("FAIL async_reset: got st=%0d cnt=%0d%0d run=%0b", state, count1, count0, lfsr_run);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    idle(10, "held_start");
    @(negedge Clock) Start_button = 1'b1;
    idle(3, "released_start");
    random = 10'h31C;
    press(1, 0, 10'h000, "rm_repress");
  endtask

  task automatic test_random();
    logic [N-1:0] gv;
    for (int g = 0; g < 8; g++) begin
      random = N'($urandom);
      press(1, 0, 10'h000, "rnd_start");
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
        case ($urandom_range(0, 3))
          0: gv = m_secret;
          1: gv = m_secret + N'($urandom_range(1, 3));
          2: gv = m_secret - N'($urandom_range(1, 3));
          default: gv = N'($urandom);
        endcase
        press(0, 1, gv, "rnd_guess");
        idle($urandom_range(0, 8), "rnd_gap");
      end
      if ($urandom_range(0, 3) == 0) begin
        random = N'($urandom);
        press(1, 0, 10'h000, "rnd_restart");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_simultaneous();
    if (!LIMIT) test_saturation();
    if (LIMIT) test_limit();
    test_reset_midgame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
